prefetch_queue: RTL and testbench

//  Parametrised fetch stage with an instruction prefetch FIFO, replacing the single-register fetch between pmem and decoder.

---
 rtl/prefetch_queue.sv | 124 ++++++++++++
 tb/tb_prefetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: fetch stage that issues sequential pmem reads ahead of the
// decoder, buffers up to DEPTH {instruction, PC} pairs and presents the oldest
// one over a valid/ready handshake. Redirect (in_set_pc) and flush (in_flush)
// empty the queue and restart fetching from the new target or the oldest
// unconsumed PC respectively.
module prefetch_queue #(
    parameter int                  PC_WIDTH     = 12,
    parameter int                  PMEM_WIDTH   = 16,
    parameter int                  PC_INCREMENT = 2,
    parameter int                  DEPTH        = 4,
    parameter int                  CNT_WIDTH    = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_set_pc,
    input  logic [PC_WIDTH-1:0]   in_new_pc,
    input  logic                  in_flush,
    output logic                  out_pmem_req,
    output logic [PC_WIDTH-1:0]   out_pmem_addr,
    input  logic [PMEM_WIDTH-1:0] in_pmem_word,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [PMEM_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_instr_pc,
    output logic [CNT_WIDTH-1:0]  out_count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   replay_pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic                  inflight;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [PMEM_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];

    logic                  redirect;
    logic                  push;
    logic                  pop;
    logic                  req;
    logic [CNT_WIDTH:0]    credit_used;

    // Issue, handshake and capture decisions; the credit ignores a same-cycle
    // pop so there is no combinational path from in_ready to the request.
    always_comb begin
        redirect    = in_set_pc | in_flush;
        credit_used = {1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight};
        req         = ~reset & ~redirect & (credit_used < (CNT_WIDTH+1)'(DEPTH));
        out_valid   = (count != '0) & ~redirect;
        pop         = out_valid & in_ready;
        push        = inflight & ~redirect;
    end

    assign out_pmem_req  = req;
    assign out_pmem_addr = fetch_pc;
    assign out_instr     = instr_mem[rd_ptr];
    assign out_instr_pc  = pc_mem[rd_ptr];
    assign out_count     = count;

    // Fetch PC, replay PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            replay_pc   <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            // Queue and any returning read are discarded.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            if (in_set_pc) begin
                fetch_pc  <= in_new_pc;
                replay_pc <= in_new_pc;
            end else begin
                fetch_pc  <= replay_pc;
            end
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_WIDTH'(PC_INCREMENT);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_WIDTH'(1);
                replay_pc <= pc_mem[rd_ptr] + PC_WIDTH'(PC_INCREMENT);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: returning read data and its PC written at wr_ptr.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= in_pmem_word;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

    // The request credit must make a push into a full queue impossible.
    no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && (count == CNT_WIDTH'(DEPTH))));

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: scenario tasks for prefetch_queue checked against a
// stream-level model: the decoder must see consecutive PCs (step 2, modulo
// 4096) starting at the reset PC, the redirect target, or the PC after the
// last consumed instruction for a flush; each word must match its PC.
module tb_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_set_pc = 1'b0;
    logic [11:0] in_new_pc = '0;
    logic        in_flush = 1'b0;
    logic        out_pmem_req;
    logic [11:0] out_pmem_addr;
    logic [15:0] in_pmem_word = '0;
    logic        out_valid;
    logic        in_ready = 1'b0;
    logic [15:0] out_instr;
    logic [11:0] out_instr_pc;
    logic [2:0]  out_count;

    int          checks = 0;
    int          passed = 0;
    logic [11:0] exp_pc = '0;

    prefetch_queue #(
        .PC_WIDTH    (12),
        .PMEM_WIDTH  (16),
        .PC_INCREMENT(2),
        .DEPTH       (4),
        .CNT_WIDTH   (3),
        .RESET_PC    (12'h000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_set_pc    (in_set_pc),
        .in_new_pc    (in_new_pc),
        .in_flush     (in_flush),
        .out_pmem_req (out_pmem_req),
        .out_pmem_addr(out_pmem_addr),
        .in_pmem_word (in_pmem_word),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .out_instr    (out_instr),
        .out_instr_pc (out_instr_pc),
        .out_count    (out_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] word_of(input logic [11:0] a);
        return {~a[3:0], a};
    endfunction

    // Program memory: one-cycle read latency.
    always @(posedge clock) begin
        if (out_pmem_req) in_pmem_word <= word_of(out_pmem_addr);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_set_pc = 1'b0; in_flush = 1'b0; in_ready = 1'b0; in_new_pc = '0;
        tick(); tick();
        reset = 1'b0;
        exp_pc = 12'h000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        settle();
        checks++;
        if (out_valid !== 1'b0 || out_pmem_req !== 1'b0 || out_pmem_addr !== 12'h000 ||
            out_instr !== 16'h0 || out_instr_pc !== 12'h000 || out_count !== 3'd0)
            $display("FAIL reset_values valid=%b req=%b addr=%h instr=%h pc=%h cnt=%0d required 0/0/000/0000/000/0",
                     out_valid, out_pmem_req, out_pmem_addr, out_instr, out_instr_pc, out_count);
        else passed++;
    endtask

    task automatic test_stream();
        int first_req = -1;
        int first_valid = -1;
        do_reset();
        in_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (out_pmem_req && first_req < 0) first_req = c;
            if (first_valid >= 0) begin
                checks++;
                if (out_valid !== 1'b1) $display("FAIL stream_throughput cycle=%0d valid=%b required 1", c, out_valid);
                else passed++;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid) begin
                checks++;
                if (out_instr_pc !== exp_pc || out_instr !== word_of(exp_pc))
                    $display("FAIL stream_order pc=%h instr=%h required pc=%h instr=%h", out_instr_pc, out_instr, exp_pc, word_of(exp_pc));
                else passed++;
                exp_pc += 12'd2;
            end
            tick();
        end
        // Request edge then capture edge before the head is valid.
        checks++;
        if (first_req != 0 || first_valid != 2)
            $display("FAIL stream_latency first_req=%0d first_valid=%0d required 0 and 2", first_req, first_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_ready = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        settle();
        checks++;
        if (out_count !== 3'd4 || out_pmem_req !== 1'b0 || out_pmem_addr !== 12'h008 || out_valid !== 1'b1)
            $display("FAIL backpressure_full cnt=%0d req=%b addr=%h valid=%b required 4/0/008/1", out_count, out_pmem_req, out_pmem_addr, out_valid);
        else passed++;
        in_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (out_valid !== 1'b1 || out_instr_pc !== exp_pc || out_instr !== word_of(exp_pc))
                $display("FAIL backpressure_drain valid=%b pc=%h instr=%h required 1 pc=%h instr=%h", out_valid, out_instr_pc, out_instr, exp_pc, word_of(exp_pc));
            else passed++;
            if (out_valid) exp_pc += 12'd2;
            tick();
        end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        int delivered = 0;
        do_reset();
        in_ready = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            settle();
            if (out_count == 3'd3) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) $display("FAIL redirect_wait count never reached 3, required 3");
        else passed++;
        in_set_pc = 1'b1; in_new_pc = 12'h100;
        settle();
        checks++;
        if (out_valid !== 1'b0 || out_pmem_req !== 1'b0)
            $display("FAIL redirect_quiet valid=%b req=%b required 0/0", out_valid, out_pmem_req);
        else passed++;
        tick();
        in_set_pc = 1'b0; exp_pc = 12'h100; in_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (out_valid) begin
                checks++;
                if (out_instr_pc !== exp_pc || out_instr !== word_of(exp_pc))
                    $display("FAIL redirect_order pc=%h instr=%h required pc=%h instr=%h", out_instr_pc, out_instr, exp_pc, word_of(exp_pc));
                else passed++;
                exp_pc += 12'd2;
                delivered++;
            end
            tick();
        end
        checks++;
        if (delivered < 8) $display("FAIL redirect_delivered count=%0d required >= 8", delivered);
        else passed++;
    endtask

    task automatic test_flush();
        int pops = 0;
        logic [11:0] first_pc = 12'hFFF;
        bit got = 1'b0;
        do_reset();
        for (int c = 0; c < 60 && pops < 2; c++) begin
            in_ready = 1'($urandom_range(0, 1));
            settle();
            if (out_valid) begin
                checks++;
                if (out_instr_pc !== exp_pc) $display("FAIL flush_prefix pc=%h required %h", out_instr_pc, exp_pc);
                else passed++;
                if (in_ready) begin exp_pc += 12'd2; pops++; end
            end
            tick();
        end
        in_ready = 1'b0; in_flush = 1'b1;
        settle();
        checks++;
        if (out_valid !== 1'b0 || out_pmem_req !== 1'b0)
            $display("FAIL flush_quiet valid=%b req=%b required 0/0", out_valid, out_pmem_req);
        else passed++;
        tick();
        in_flush = 1'b0; in_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (out_valid && !got) begin first_pc = out_instr_pc; got = 1'b1; end
            tick();
        end
        checks++;
        if (first_pc !== 12'h004) $display("FAIL flush_replay first_pc=%h required 004", first_pc);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [11:0] seen [3];
        int n = 0;
        for (int i = 0; i < 3; i++) seen[i] = 12'h555;
        in_set_pc = 1'b1; in_new_pc = 12'hFFE; in_ready = 1'b1;
        tick();
        in_set_pc = 1'b0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (out_valid && n < 3) begin seen[n] = out_instr_pc; n++; end
            tick();
        end
        checks++;
        if (seen[0] !== 12'hFFE || seen[1] !== 12'h000 || seen[2] !== 12'h002)
            $display("FAIL wrap_pcs got %h %h %h required ffe 000 002", seen[0], seen[1], seen[2]);
        else passed++;
    endtask

    task automatic test_random();
        bit prev_stall = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_ready = ($urandom_range(0, 3) != 0);
            in_flush = ($urandom_range(0, 19) == 0);
            in_set_pc = ($urandom_range(0, 24) == 0);
            in_new_pc = 12'($urandom) & 12'hFFE;
            settle();
            if (in_flush || in_set_pc) begin
                checks++;
                if (out_valid !== 1'b0 || out_pmem_req !== 1'b0)
                    $display("FAIL random_redirect_quiet cycle=%0d valid=%b req=%b required 0/0", c, out_valid, out_pmem_req);
                else passed++;
                if (in_set_pc) exp_pc = in_new_pc;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1) $display("FAIL random_hold cycle=%0d valid=%b required 1", c, out_valid);
                    else passed++;
                end
                if (out_valid) begin
                    checks++;
                    if (out_instr_pc !== exp_pc || out_instr !== word_of(exp_pc))
                        $display("FAIL random_order cycle=%0d pc=%h instr=%h required pc=%h instr=%h", c, out_instr_pc, out_instr, exp_pc, word_of(exp_pc));
                    else passed++;
                    if (in_ready) exp_pc += 12'd2;
                end
                prev_stall = out_valid && !in_ready;
            end
            checks++;
            if (out_count > 3'd4) $display("FAIL random_count cycle=%0d cnt=%0d required <= 4", c, out_count);
            else passed++;
            tick();
        end
        in_flush = 1'b0; in_set_pc = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        logic [11:0] first_pc = 12'hFFF;
        bit got = 1'b0;
        do_reset();
        in_ready = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            settle();
            if (out_count == 3'd3) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) $display("FAIL reset_mid_wait count never reached 3, required 3");
        else passed++;
        // Away from any clock edge: reset must act immediately.
        #3 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pmem_req !== 1'b0 || out_pmem_addr !== 12'h000 ||
            out_instr !== 16'h0 || out_instr_pc !== 12'h000 || out_count !== 3'd0)
            $display("FAIL reset_mid_async valid=%b req=%b addr=%h instr=%h pc=%h cnt=%0d required 0/0/000/0000/000/0",
                     out_valid, out_pmem_req, out_pmem_addr, out_instr, out_instr_pc, out_count);
        else passed++;
        tick();
        reset = 1'b0; in_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (out_valid && !got) begin first_pc = out_instr_pc; got = 1'b1; end
            tick();
        end
        checks++;
        if (first_pc !== 12'h000) $display("FAIL reset_mid_restart first_pc=%h required 000", first_pc);
        else passed++;
    endtask

    initial begin
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
